// File: rtl/fpu_div_pkg.sv
// Shared widths, divide-by-zero quotient and controller state encoding for the divider arbiter.
package fpu_div_pkg;

    localparam int MANT_W = 48;
    localparam int QUOT_W = 25;

    localparam logic [QUOT_W-1:0] DBZ_QUOT = 25'h1FFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        WAIT_LO,
        WAIT_HI,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick starting at last_grant+1; purely combinational, grant gated by i_advance.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx
);

    logic w_found;

    // k walks the rotation order; j keeps every select index a constant.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && i_req[j] && (((int'(i_last_grant) + k) % NUM_REQ) == j)) begin
                    w_found   = 1'b1;
                    o_gnt[j]  = i_advance;
                    o_gnt_idx = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fpu_div_arbiter.sv
// Shares one 48-bit mantissa divider among NUM_REQ requesters: accept, arm, start, wait done, respond.
// Response 52 cycles after accept (1 for divide-by-zero); optional watchdog via FPU_DIVARB_TIMEOUT_EN.
module fpu_div_arbiter
    import fpu_div_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*MANT_W-1:0]   req_dividend,
    input  logic [NUM_REQ*MANT_W-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [QUOT_W-1:0]           resp_quot,
    output logic                        resp_dbz,
    output logic                        resp_err,
    output logic                        div_en,
    output logic [MANT_W-1:0]           div_dividend,
    output logic [MANT_W-1:0]           div_divisor,
    input  logic                        div_done,
    input  logic [QUOT_W-1:0]           div_quot
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 127) begin : g_param_check
        $error("fpu_div_arbiter: NUM_REQ or TIMEOUT_CYC out of range");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_last_grant;
    logic [NUM_REQ-1:0]   r_gnt_oh;
    logic [MANT_W-1:0]    r_dividend;
    logic [MANT_W-1:0]    r_divisor;
    logic [QUOT_W-1:0]    r_quot;
    logic                 r_dbz;

    logic                 w_advance;
    logic                 w_accept;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic [MANT_W-1:0]    w_sel_dividend;
    logic [MANT_W-1:0]    w_sel_divisor;
    logic                 w_waiting;
    logic                 w_timeout;

    // Accept only with the divider idle (done high), so a divider still counting after reset is never reused early.
    assign w_advance = (r_state == IDLE) && div_done && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .i_advance    (w_advance),
        .o_gnt        (w_gnt),
        .o_gnt_idx    (w_gnt_idx)
    );

    assign w_accept  = |w_gnt;
    assign req_ready = w_gnt;

    always_comb begin
        w_sel_dividend = '0;
        w_sel_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == IDX_W'(i)) begin
                w_sel_dividend = req_dividend[i*MANT_W +: MANT_W];
                w_sel_divisor  = req_divisor[i*MANT_W +: MANT_W];
            end
        end
    end

    assign w_waiting = (r_state == WAIT_LO) || (r_state == WAIT_HI);

`ifdef FPU_DIVARB_TIMEOUT_EN
    logic [6:0] r_wdog;
    logic       r_err;

    // A done arriving on the limit cycle wins over the abort.
    assign w_timeout = w_waiting && (r_wdog == 7'(TIMEOUT_CYC - 1)) &&
                       !((r_state == WAIT_HI) && div_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= w_waiting ? r_wdog + 7'd1 : 7'd0;
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign resp_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign resp_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_sel_divisor == '0) ? RESP : ARM;
                end
            end
            ARM:     w_state_nxt = START;
            START:   w_state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (w_timeout) begin
                    w_state_nxt = RESP;
                end else if (!div_done) begin
                    w_state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (div_done || w_timeout) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_gnt_oh     <= '0;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_quot       <= '0;
            r_dbz        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_gnt_idx;
                r_gnt_oh     <= w_gnt;
                r_dividend   <= w_sel_dividend;
                r_divisor    <= w_sel_divisor;
                r_dbz        <= (w_sel_divisor == '0);
                r_quot       <= (w_sel_divisor == '0) ? DBZ_QUOT : '0;
            end else if ((r_state == WAIT_HI) && div_done) begin
                r_quot <= div_quot;
            end else if (w_timeout) begin
                r_quot <= '0;
            end
        end
    end

    assign div_en       = (r_state == START) || w_waiting;
    assign div_dividend = r_dividend;
    assign div_divisor  = r_divisor;
    assign resp_valid   = (r_state == RESP) ? r_gnt_oh : '0;
    assign resp_quot    = r_quot;
    assign resp_dbz     = r_dbz;

endmodule

// File: doc/fpu_div_arbiter.md
Name: fpu_div_arbiter

Overview:
Shares the single 48-bit non-restoring mantissa divider between NUM_REQ FPU requesters (e.g. div and sqrt-seed paths).
- Round-robin grant; one operation in flight.
- Sequences the divider's en/done protocol: arm, start, wait for done low, then wait for done high.
- Captures the 25-bit quotient and returns it with a one-cycle response pulse to the granted requester.
- Short-circuits divide-by-zero without using the divider.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
clk  in  1  single clock, all logic on posedge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester operation request.
req_ready  out  NUM_REQ  one-hot accept pulse; handshake completes when req_valid[i] and req_ready[i] are both high.
req_dividend  in  NUM_REQ*48  packed dividends; requester i uses bits [48i+47:48i].
req_divisor  in  NUM_REQ*48  packed divisors, same packing.
resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse.
resp_quot  out  25  quotient; valid only while resp_valid is nonzero.
resp_dbz  out  1  divide-by-zero flag, qualified by resp_valid.
resp_err  out  1  timeout abort flag; tied 0 without the macro.
div_en  out  1  to divider en.
div_dividend  out  48  to divider dividend; held stable from ARM through CAPTURE.
div_divisor  out  48  to divider divisor; held stable from ARM through CAPTURE.
div_done  in  1  from divider done.
div_quot  in  25  from divider longQ; valid only while div_done=1.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_quot=0, resp_dbz=0, resp_err=0, div_en=0, operand regs=0, rr pointer grants req0 first, state=IDLE.
- States: IDLE, ARM, START, WAIT_LO, WAIT_HI, RESP.
- IDLE: div_en=0. Accepts only when div_done=1 and some req_valid is high.
  - The rr_arbiter picks the highest-priority requester, starting from last_grant+1 mod NUM_REQ.
  - req_ready pulses for one cycle in that requester's bit; operands are latched in the same cycle.
  - If the latched divisor is 0: go to RESP with resp_quot=25'h1FFFFFF and resp_dbz=1.
  - Otherwise: go to ARM.
- ARM: div_en=0 for exactly one cycle, so the divider sees done=1 with en=0 and arms. Go to START.
- START: div_en=1. Go to WAIT_LO.
- WAIT_LO: div_en=1. On div_done=0, go to WAIT_HI.
- WAIT_HI: div_en=1. On div_done=1, capture div_quot, drop div_en to 0, and go to RESP.
- RESP: resp_valid is one-hot for one cycle with resp_quot/resp_dbz registered. Go to IDLE. The last_grant update happens at accept.
- Latency: handshake at cycle 0, ARM at 1, START at 2, divider iterates 48 cycles, done rises at cycle 51, resp_valid at cycle 52. Divide-by-zero: resp_valid at cycle 1.
- Throughput: the next accept is possible in the cycle after RESP, so back-to-back operations are 53 cycles apart.
- Requests arriving while busy wait. req_valid must be held until req_ready; dropping it early simply withdraws the request.
- Simultaneous requests: strict rotation. With all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1.
- Reset mid-operation: the block returns to IDLE with div_en=0 and no response. The divider has no reset and may still be counting. IDLE blocks accept until div_done=1, so no stale quotient is ever delivered.
- There is no response backpressure; requesters must sample resp_valid.

Optional Feature:
FPU_DIVARB_TIMEOUT_EN
- Defined: a 7-bit watchdog counts cycles in WAIT_LO and WAIT_HI.
  - On reaching TIMEOUT_CYC it aborts to RESP with resp_err=1, resp_quot=0 and div_en=0.
  - The IDLE accept rule (div_done=1) still applies afterwards.
- Undefined: no counter; resp_err is constant 0 and the block waits indefinitely.

Decomposition:
- Package fpu_div_pkg: MANT_W=48, QUOT_W=25, DBZ_QUOT=25'h1FFFFFF, and the state enum (IDLE, ARM, START, WAIT_LO, WAIT_HI, RESP).
- Sub-module rr_arbiter (parameter NUM_REQ): inputs req vector, last_grant pointer and advance; outputs one-hot grant and its encoded index. The FSM and datapath stay in fpu_div_arbiter.

Test Plan:
- Single op: req0 with dividend=48'h91EC91000000, divisor=48'h000000EC0000 -> req_ready[0] at cycle 0; div_en low at cycle 1, high from cycle 2; resp_valid=2'b01 at cycle 52; resp_quot equals the bit-accurate divider model value.
- Contention: req0 and req1 valid together for 4 operations -> grant order 0,1,0,1; each resp_valid goes to the matching bit; accepts exactly 53 cycles apart.
- Divide-by-zero: req1 with divisor=0 -> resp_valid=2'b10 at cycle 1, resp_quot=25'h1FFFFFF, resp_dbz=1; div_en never rises.
- Reset mid-op: assert rst at cycle 20 of an operation -> no resp_valid; a new request is not accepted until div_done returns to 1; the following operation completes correctly.
- Timeout (macro defined, TIMEOUT_CYC=16, divider model holding done low) -> resp_valid with resp_err=1 and resp_quot=0, 16 cycles after entering WAIT_LO; then back in IDLE.
